// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: immediate formats, NOP encoding, widths.
// Also provides the immediate-extender helper used by the decode stage.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_t;

   // Unused encodings yield zero so a bogus ImmSrcD cannot leak instruction bits.
   function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] i,
                                                  input logic [2:0]  src);
      logic [XLEN-1:0] imm;
      imm = '0;
      case (src)
         IMM_I:   imm = {{20{i[31]}}, i[31:20]};
         IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
         IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         IMM_U:   imm = {i[31:12], 12'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/d_stage_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, x0 tied to zero.
// Compile with REGFILE_BYPASS_EN to forward a same-cycle write to the read ports.
module regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [NREGS-1:0][XLEN-1:0] regs_bus;
   logic [1:0][AW-1:0]         raddr_bus;
   logic [1:0][XLEN-1:0]       rdata_bus;

   assign regs_bus[0] = '0;

   // One flop bank per architectural register; reset wins over a same-cycle write.
   for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
      logic [XLEN-1:0] q_reg;
      always_ff @(posedge clk) begin
         if (rst) begin
            q_reg <= '0;
         end else if (we && (waddr == AW'(gi))) begin
            q_reg <= wdata;
         end
      end
      assign regs_bus[gi] = q_reg;
   end

   assign raddr_bus[0] = raddr1;
   assign raddr_bus[1] = raddr2;

   for (genvar gi = 0; gi < 2; gi++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
      assign rdata_bus[gi] = (we && (waddr != '0) && (waddr == raddr_bus[gi]))
                             ? wdata : regs_bus[raddr_bus[gi]];
`else
      assign rdata_bus[gi] = regs_bus[raddr_bus[gi]];
`endif
   end

   assign rdata1 = rdata_bus[0];
   assign rdata2 = rdata_bus[1];

endmodule

// File: rtl/flop_r.sv
// Enabled register with synchronous reset and synchronous clear to a fixed value.
// Priority: rst > clr > en.
module flop_r #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= RESET_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/d_stage.sv
// RV32I decode stage: IF/ID register, register file and immediate extender.
// Optional same-cycle writeback forwarding: define REGFILE_BYPASS_EN.
module d_stage #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             StallD,
   input  logic                             FlushD,
   input  logic [31:0]                      InstrF,
   input  logic [XLEN-1:0]                  pcF,
   input  logic [XLEN-1:0]                  PCPlus4F,
   input  logic [2:0]                       ImmSrcD,
   input  logic                             RegWriteW,
   input  logic [riscv_pkg::REG_ADDR_W-1:0] RdW,
   input  logic [XLEN-1:0]                  ResultW,
   output logic [31:0]                      InstrD,
   output logic [XLEN-1:0]                  pcD,
   output logic [XLEN-1:0]                  PCPlus4D,
   output logic [riscv_pkg::REG_ADDR_W-1:0] Rs1D,
   output logic [riscv_pkg::REG_ADDR_W-1:0] Rs2D,
   output logic [riscv_pkg::REG_ADDR_W-1:0] RdD,
   output logic [XLEN-1:0]                  RD1D,
   output logic [XLEN-1:0]                  RD2D,
   output logic [XLEN-1:0]                  ImmExtD
);
   import riscv_pkg::*;

   localparam int IFID_W = 32 + 2 * XLEN;

   logic [IFID_W-1:0] ifid_d;
   logic [IFID_W-1:0] ifid_q;

   assign ifid_d = {InstrF, pcF, PCPlus4F};

   // A flushed or reset slot holds a NOP with zeroed PCs.
   flop_r #(
      .WIDTH     (IFID_W),
      .RESET_VAL ({NOP_INSTR, {(2 * XLEN){1'b0}}})
   ) u_ifid (
      .clk (clk),
      .rst (rst),
      .en  (~StallD),
      .clr (FlushD),
      .d   (ifid_d),
      .q   (ifid_q)
   );

   assign InstrD   = ifid_q[IFID_W-1 -: 32];
   assign pcD      = ifid_q[2*XLEN-1 -: XLEN];
   assign PCPlus4D = ifid_q[XLEN-1:0];

   assign Rs1D = InstrD[19:15];
   assign Rs2D = InstrD[24:20];
   assign RdD  = InstrD[11:7];

   regfile #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (REG_ADDR_W)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we     (RegWriteW),
      .waddr  (RdW),
      .wdata  (ResultW),
      .raddr1 (Rs1D),
      .raddr2 (Rs2D),
      .rdata1 (RD1D),
      .rdata2 (RD2D)
   );

   assign ImmExtD = imm_extend(InstrD, ImmSrcD);

endmodule
